// File: rtl/uart_pkg.sv
// Shared types and baud-rate helpers for the UART controller.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

    // Rounded to nearest so the oversample grid stays close to the true bit period.
    function automatic int unsigned oversample_div(input int unsigned clock_rate,
                                                   input int unsigned baud_rate,
                                                   input int unsigned oversample);
        int unsigned den;
        den = baud_rate * oversample;
        return (clock_rate + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider that emits a one-cycle tick every DIV clocks while enabled.
module uart_baud_tick #(
    parameter int unsigned DIV = 217
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Holding the count at zero while disabled aligns the first tick to the enable edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/uart_controller.sv
// 8N1 UART with independent TX and oversampling RX FSMs and optional internal loopback.
module uart_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE    = 25000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned RX_OVERSAMPLE = 16,
    parameter int unsigned LOOPBACK      = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Tx_Ready,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Data,
    output logic       o_Tx_Done,
    input  logic       i_Rx_Data,
    output logic       o_Rx_Done,
    output logic [7:0] o_Rx_Byte
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned OS_DIV       = oversample_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
    localparam int unsigned TW           = $clog2(RX_OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST  = TW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST  = TW'(RX_OVERSAMPLE - 1);

    tx_state_t  tx_state;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;
    logic       tx_tick;

    rx_state_t     rx_state;
    logic          rx_in;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [TW-1:0] rx_ticks;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick;

    uart_baud_tick #(.DIV(CLKS_PER_BIT)) u_tx_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tx_state != TX_IDLE),
        .tick    (tx_tick)
    );

    uart_baud_tick #(.DIV(OS_DIV)) u_rx_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (rx_state != RX_IDLE),
        .tick    (rx_tick)
    );

    // Transmitter: o_Tx_Data is registered, so each bit starts on the edge that ends the previous one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_bit      <= '0;
            o_Tx_Data   <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (i_Tx_Ready) begin
                        tx_shift    <= i_Tx_Byte;
                        tx_bit      <= '0;
                        o_Tx_Data   <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        tx_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        o_Tx_Data <= tx_shift[0];
                        tx_shift  <= {1'b0, tx_shift[7:1]};
                        tx_state  <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == 3'd7) begin
                            o_Tx_Data <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            o_Tx_Data <= tx_shift[0];
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                            tx_bit    <= tx_bit + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        tx_state    <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign rx_in = (LOOPBACK != 0) ? o_Tx_Data : i_Rx_Data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Edge detection needs rx_prev high, so after a framing error the line must idle high before re-arming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            rx_ticks  <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            o_Rx_Byte <= '0;
            o_Rx_Done <= 1'b0;
        end else begin
            o_Rx_Done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_ticks <= '0;
                    rx_bit   <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_ticks == HALF_LAST) begin
                            rx_ticks <= '0;
                            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_ticks <= rx_ticks + TW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        if (rx_ticks == FULL_LAST) begin
                            rx_ticks <= '0;
                            rx_shift <= {rx_sync, rx_shift[7:1]};
                            if (rx_bit == 3'd7) begin
                                rx_state <= RX_STOP;
                            end else begin
                                rx_bit <= rx_bit + 3'd1;
                            end
                        end else begin
                            rx_ticks <= rx_ticks + TW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_ticks == FULL_LAST) begin
                            rx_ticks <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_sync) begin
                                o_Rx_Byte <= rx_shift;
                                o_Rx_Done <= 1'b1;
                            end
                        end else begin
                            rx_ticks <= rx_ticks + TW'(1);
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: TX framing/timing, RX, framing error, glitch, loopback, reset abort.
`timescale 1ns/1ps
module tb_uart_controller;

    localparam int CPB    = 25000000 / 115200;
    localparam int FRAME  = 10 * CPB;
    localparam int BUDGET = 3 * FRAME;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_line = 1'b1;

    logic       tx_ready0, tx_ready1;
    logic [7:0] tx_byte0, tx_byte1;
    logic       tx_active0, tx_active1;
    logic       tx_data0, tx_data1;
    logic       tx_done0, tx_done1;
    logic       rx_done0, rx_done1;
    logic [7:0] rx_byte0, rx_byte1;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] lb_q[$];
    logic [7:0] burst[$];
    logic [7:0] last_rx;
    logic [7:0] tx_exp;
    logic [7:0] rx_exp0, rx_exp1;
    logic       tx_prev;

    always #5 clk = ~clk;

    uart_controller #(
        .CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_Tx_Ready(tx_ready0), .i_Tx_Byte(tx_byte0),
        .o_Tx_Active(tx_active0), .o_Tx_Data(tx_data0), .o_Tx_Done(tx_done0),
        .i_Rx_Data(rx_line), .o_Rx_Done(rx_done0), .o_Rx_Byte(rx_byte0)
    );

    uart_controller #(
        .CLOCK_RATE(25000000), .BAUD_RATE(115200), .RX_OVERSAMPLE(16), .LOOPBACK(1)
    ) dut_lb (
        .clk(clk), .reset_n(reset_n),
        .i_Tx_Ready(tx_ready1), .i_Tx_Byte(tx_byte1),
        .o_Tx_Active(tx_active1), .o_Tx_Data(tx_data1), .o_Tx_Done(tx_done1),
        .i_Rx_Data(rx_line), .o_Rx_Done(rx_done1), .o_Rx_Byte(rx_byte1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Line level of frame bit k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // TX monitor: every frame must hold each bit exactly CPB clocks and end with a Done pulse.
    initial begin : tx_monitor
        tx_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                tx_prev = 1'b0;
            end else if (!tx_prev && tx_active0) begin
                if (tx_q.size() == 0) begin
                    flag("tx_unexpected_frame");
                    tx_exp = 8'h00;
                end else begin
                    tx_exp = tx_q.pop_front();
                end
                for (int c = 0; c <= FRAME; c++) begin
                    if (c > 0) begin
                        @(posedge clk); #1;
                    end
                    if (!reset_n) break;
                    if (c < FRAME && ((c % CPB) == 0 || (c % CPB) == CPB - 1))
                        check("tx_bit", tx_data0, frame_bit(tx_exp, c / CPB));
                    if (c == FRAME - 1)
                        check("tx_last_stop_cycle", {tx_active0, tx_done0}, 2'b10);
                    if (c == FRAME)
                        check("tx_done_end", {tx_active0, tx_done0, tx_data0}, 3'b011);
                end
                tx_prev = reset_n ? tx_active0 : 1'b0;
            end else begin
                if (tx_done0) flag("tx_done_outside_frame");
                tx_prev = tx_active0;
            end
        end
    end

    always begin : rx_monitor
        @(posedge clk); #1;
        if (reset_n && rx_done0) begin
            if (rx_q.size() == 0) begin
                flag("rx_unexpected_done");
            end else begin
                rx_exp0 = rx_q.pop_front();
                check("rx_byte", rx_byte0, rx_exp0);
            end
        end
    end

    always begin : lb_monitor
        @(posedge clk); #1;
        if (reset_n && rx_done1) begin
            if (lb_q.size() == 0) begin
                flag("lb_unexpected_done");
            end else begin
                rx_exp1 = lb_q.pop_front();
                check("lb_byte", rx_byte1, rx_exp1);
            end
        end
    end

    task automatic set_tx(input int sel, input logic ready, input logic [7:0] b);
        if (sel == 0) begin
            tx_ready0 = ready;
            tx_byte0  = b;
        end else begin
            tx_ready1 = ready;
            tx_byte1  = b;
        end
    endtask

    task automatic expect_tx(input int sel, input logic [7:0] b);
        if (sel == 0) tx_q.push_back(b);
        else lb_q.push_back(b);
    endtask

    task automatic wait_tx(input int sel, input bit for_done, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (for_done) hit = (sel == 0) ? tx_done0 : tx_done1;
            else          hit = (sel == 0) ? tx_active0 : tx_active1;
        end
        if (!hit) flag(name);
    endtask

    // Holds ready high across the burst; the next byte is presented right after each latch.
    task automatic send_tx_burst(input int sel, input logic [7:0] bytes[$]);
        expect_tx(sel, bytes[0]);
        set_tx(sel, 1'b1, bytes[0]);
        wait_tx(sel, 1'b0, "tx_latch_timeout");
        for (int i = 1; i < bytes.size(); i++) begin
            expect_tx(sel, bytes[i]);
            set_tx(sel, 1'b1, bytes[i]);
            wait_tx(sel, 1'b1, "tx_done_timeout");
            wait_tx(sel, 1'b0, "tx_latch_timeout");
        end
        set_tx(sel, 1'b0, 8'($urandom));
        wait_tx(sel, 1'b1, "tx_done_timeout");
    endtask

    task automatic rx_bit(input logic v);
        rx_line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
    endtask

    task automatic rx_sequence();
        logic [7:0] b;
        rx_q.push_back(8'h55);
        rx_frame(8'h55, 1'b1);
        last_rx = 8'h55;
        repeat (3) begin
            b = 8'($urandom_range(0, 255));
            rx_q.push_back(b);
            rx_frame(b, 1'b1);
            last_rx = b;
        end
        rx_frame(8'hA5, 1'b0);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("rx_byte_after_framing_error", rx_byte0, last_rx);
        rx_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        last_rx = 8'h3C;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("rx_byte_after_glitch", rx_byte0, last_rx);
        b = 8'($urandom_range(0, 255));
        rx_q.push_back(b);
        rx_frame(b, 1'b1);
        rx_line = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        tx_ready0 = 1'b0; tx_byte0 = 8'h00;
        tx_ready1 = 1'b0; tx_byte1 = 8'h00;
        last_rx = 8'h00;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_tx_data",   tx_data0,   1'b1);
        check("reset_tx_active", tx_active0, 1'b0);
        check("reset_tx_done",   tx_done0,   1'b0);
        check("reset_rx_done",   rx_done0,   1'b0);
        check("reset_rx_byte",   rx_byte0,   8'h00);
        check("reset_lb_tx_data", tx_data1,  1'b1);
        check("reset_lb_active", tx_active1, 1'b0);
        check("reset_lb_rx_byte", rx_byte1,  8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // TX burst and RX traffic run concurrently on the same instance.
        burst = {8'h55};
        repeat (4) burst.push_back(8'($urandom_range(0, 255)));
        fork
            send_tx_burst(0, burst);
            rx_sequence();
        join

        burst = {8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};
        send_tx_burst(1, burst);
        repeat (500) @(negedge clk);

        // Reset in the middle of frame bit 4 (data bit 3 forced to 0 so the line is low there).
        tx_byte0 = 8'($urandom_range(0, 255)) & 8'hF7;
        tx_q.push_back(tx_byte0);
        tx_ready0 = 1'b1;
        wait_tx(0, 1'b0, "tx_reset_latch_timeout");
        tx_ready0 = 1'b0;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #1;
        check("tx_midframe_before_reset", {tx_active0, tx_data0}, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        check("tx_reset_abort_data",   tx_data0,   1'b1);
        check("tx_reset_abort_active", tx_active0, 1'b0);
        check("tx_reset_abort_done",   tx_done0,   1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME + CPB) @(negedge clk);
        check("tx_idle_after_reset", {tx_active0, tx_data0}, 2'b01);
        check("rx_byte_after_reset", rx_byte0, 8'h00);

        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);
        check("lb_queue_drained", lb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
